// File: rtl/md_pkg.sv
// Shared definitions for the hazard / mult-div scheduler.
// Timing widths, HI/LO op encodings and default unit latencies.
package md_pkg;

    localparam int T_W = 2;
    localparam int CNT_W = 4;

    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Producer in a later stage still owes its result past the consumer's need.
    function automatic logic src_hazard(
        input logic [4:0]     src,
        input logic [T_W-1:0] tuse,
        input logic [4:0]     e_wa,
        input logic [T_W-1:0] e_tnew,
        input logic [4:0]     m_wa,
        input logic [T_W-1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((e_wa == src) && (e_tnew > tuse)) ||
                ((m_wa == src) && (m_tnew > tuse)));
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO unit busy counter: latency countdown, write strobe, sticky error.
// A start arriving while the unit is busy is dropped and flagged.
module md_busy_counter
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op,
    output logic busy,
    output logic we,
    output logic err
);

    localparam logic [CNT_W-1:0] IDLE = '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= IDLE;
            err <= 1'b0;
        end else if (cnt == IDLE) begin
            if (start) begin
                cnt <= (op == MD_OP_DIV) ? CNT_W'(DIV_CYCLES)
                                         : CNT_W'(MULT_CYCLES);
            end
        end else begin
            cnt <= cnt - 1'b1;
            if (start) begin
                err <= 1'b1;
            end
        end
    end

    assign busy = (cnt != IDLE);
    assign we   = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_md_ctrl.sv
// D->E issue control: data and HI/LO hazards, bubble insertion,
// HI/LO busy tracking and a saturating stall-cycle counter.
module hazard_md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_op,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic        md_busy,
    output logic        md_hilo_we,
    output logic        md_err,
    output logic [31:0] stall_cycles
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;
    logic [31:0] stall_cnt_q;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .op    (E_md_op),
        .busy  (md_busy),
        .we    (md_hilo_we),
        .err   (md_err)
    );

    assign stall_rs = src_hazard(D_rs_addr, D_Tuse_rs,
                                 E_wa, E_Tnew, M_wa, M_Tnew);
    assign stall_rt = src_hazard(D_rt_addr, D_Tuse_rt,
                                 E_wa, E_Tnew, M_wa, M_Tnew);
    assign stall_md = D_is_md && (E_md_start || md_busy);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign stall_F = stall;
    assign stall_D = stall;
    assign flush_E = stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Directed and random checks of hazard_md_ctrl against a cycle-indexed
// reference model of the HI/LO unit and the hazard rules.
module tb_hazard_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        D_is_md, E_md_start, E_md_op;
    logic        stall_F, stall_D, flush_E;
    logic        md_busy, md_hilo_we, md_err;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    longint cyc = 0;
    longint md_s = -1000;
    longint md_len = 0;
    bit     m_err = 0;
    logic [31:0] m_sc = 0;

    logic o_stall, o_busy, o_we, o_err;

    hazard_md_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs_addr    (D_rs_addr),
        .D_rt_addr    (D_rt_addr),
        .D_Tuse_rs    (D_Tuse_rs),
        .D_Tuse_rt    (D_Tuse_rt),
        .D_is_md      (D_is_md),
        .E_wa         (E_wa),
        .E_Tnew       (E_Tnew),
        .M_wa         (M_wa),
        .M_Tnew       (M_Tnew),
        .E_md_start   (E_md_start),
        .E_md_op      (E_md_op),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .flush_E      (flush_E),
        .md_busy      (md_busy),
        .md_hilo_we   (md_hilo_we),
        .md_err       (md_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_stall(input int src, input int tuse);
        return (src != 0) &&
               ((int'(E_wa) == src && int'(E_Tnew) > tuse) ||
                (int'(M_wa) == src && int'(M_Tnew) > tuse));
    endfunction

    task automatic idle_inputs();
        D_rs_addr = 0; D_rt_addr = 0;
        D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        D_is_md = 0; E_wa = 0; E_Tnew = 0;
        M_wa = 0; M_Tnew = 0;
        E_md_start = 0; E_md_op = 0;
    endtask

    // Called at a negedge with inputs set; checks, crosses posedge,
    // advances the model, returns at the next negedge.
    task automatic step();
        bit eb, ew, es;
        #1;
        eb = (cyc > md_s) && (cyc <= md_s + md_len);
        ew = eb && (cyc == md_s + md_len);
        es = src_stall(int'(D_rs_addr), int'(D_Tuse_rs)) ||
             src_stall(int'(D_rt_addr), int'(D_Tuse_rt)) ||
             (D_is_md && (E_md_start || eb));
        o_stall = stall_D; o_busy = md_busy;
        o_we = md_hilo_we; o_err = md_err;
        chk("stall_F", 32'(stall_F), 32'(es));
        chk("stall_D", 32'(stall_D), 32'(es));
        chk("flush_E", 32'(flush_E), 32'(es));
        chk("md_busy", 32'(md_busy), 32'(eb));
        chk("md_hilo_we", 32'(md_hilo_we), 32'(ew));
        chk("md_err", 32'(md_err), 32'(m_err));
        chk("stall_cycles", stall_cycles, m_sc);
        @(posedge clk);
        if (!reset) begin
            md_s = -1000; md_len = 0; m_err = 0; m_sc = 0;
        end else begin
            if (es && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (E_md_start) begin
                if (eb) m_err = 1;
                else begin
                    md_s = cyc;
                    md_len = E_md_op ? 10 : 5;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0; step(); reset = 1;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        @(negedge clk);
        step();
        step();
        reset = 1;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_sc", stall_cycles, 32'd0);

        // mult timing
        E_md_start = 1; E_md_op = 0; step();
        E_md_start = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t1_busy", 32'(o_busy), 32'(i <= 5));
            chk("t1_we", 32'(o_we), 32'(i == 5));
        end

        // mflo blocked by mult
        do_reset();
        D_is_md = 1;
        for (int i = 0; i <= 6; i++) begin
            E_md_start = (i == 0);
            step();
            chk("t2_stall", 32'(o_stall), 32'(i <= 5));
        end
        chk("t2_sc", stall_cycles, 32'd6);
        idle_inputs();

        // load-use
        E_wa = 8; E_Tnew = 2; D_rs_addr = 8; D_Tuse_rs = 1;
        step();
        chk("t3_lu", 32'(o_stall), 32'd1);
        E_wa = 0; E_Tnew = 0; M_wa = 8; M_Tnew = 1;
        step();
        chk("t3_fwd", 32'(o_stall), 32'd0);
        M_wa = 0; M_Tnew = 0; E_wa = 8; E_Tnew = 2; D_rs_addr = 0;
        step();
        chk("t3_r0", 32'(o_stall), 32'd0);
        idle_inputs();

        // div then reset mid-operation
        E_md_start = 1; E_md_op = 1; step();
        idle_inputs();
        for (int i = 1; i <= 3; i++) step();
        reset = 0; step(); reset = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t4_busy", 32'(o_busy), 32'd0);
            chk("t4_we", 32'(o_we), 32'd0);
        end

        // start while busy
        for (int t = 0; t <= 6; t++) begin
            E_md_start = (t == 0 || t == 2); E_md_op = 0;
            step();
            if (t == 2) chk("t5_err_pre", 32'(o_err), 32'd0);
            if (t >= 3) chk("t5_err", 32'(o_err), 32'd1);
            if (t >= 1) chk("t5_we", 32'(o_we), 32'(t == 5));
        end
        idle_inputs();

        // stall counter saturation
        do_reset();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_sc = 32'hFFFF_FFFE;
        E_wa = 8; E_Tnew = 2; D_rs_addr = 8; D_Tuse_rs = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_sat", stall_cycles, 32'hFFFF_FFFF);
        end
        idle_inputs();

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            D_rs_addr = 5'($urandom_range(0, 3));
            D_rt_addr = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom);
            D_Tuse_rt = 2'($urandom);
            D_is_md = ($urandom_range(0, 3) == 0);
            E_wa = 5'($urandom_range(0, 3));
            E_Tnew = 2'($urandom);
            M_wa = 5'($urandom_range(0, 3));
            M_Tnew = 2'($urandom);
            E_md_start = ($urandom_range(0, 5) == 0);
            E_md_op = 1'($urandom);
            reset = ($urandom_range(0, 63) != 0);
            step();
        end
        reset = 1;
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
